// File: rtl/mc_ifu_pkg.sv
// -----------------------------------------------------------------------------
// mc_ifu_pkg
// Shared definitions for the multi-cycle instruction fetch unit:
//   - default program base address and instruction memory depth
//   - next-PC source encodings (npc_sel_e)
//   - fetch FSM state encodings (state_e)
//   - next-PC computation and address legality helpers
// -----------------------------------------------------------------------------
package mc_ifu_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam int          IM_WORDS_DEF = 1024;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'b00,  // sequential
    NPC_BR  = 2'b01,  // conditional PC-relative branch
    NPC_J   = 2'b10,  // pseudo-direct jump
    NPC_JR  = 2'b11   // register target
  } npc_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Candidate next PC. Only the low 26 instruction bits are ever consumed
  // (branch offset in [15:0], jump target in [25:0]).
  function automatic logic [31:0] calc_npc(
    input npc_sel_e    sel,
    input logic [31:0] pc,
    input logic [25:0] ir_low,
    input logic        br_taken,
    input logic [31:0] rs_val
  );
    logic [31:0] pc4;
    logic [31:0] br_off;
    pc4    = pc + 32'd4;
    br_off = {{14{ir_low[15]}}, ir_low[15:0], 2'b00};
    unique case (sel)
      NPC_PC4: calc_npc = pc4;
      NPC_BR:  calc_npc = br_taken ? (pc4 + br_off) : pc4;
      NPC_J:   calc_npc = {pc[31:28], ir_low, 2'b00};
      NPC_JR:  calc_npc = rs_val;
      default: calc_npc = pc4;
    endcase
  endfunction

  // A PC is legal when it is word aligned and its word index relative to
  // base falls inside the memory. Addresses below base wrap to a huge
  // offset, so a single unsigned compare covers both ends of the range.
  function automatic logic addr_ok(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned words
  );
    logic [31:0] off;
    off     = addr - base;
    addr_ok = (off[1:0] == 2'b00) && ((off >> 2) < words);
  endfunction

endpackage

// File: rtl/mc_ifu_imem.sv
// -----------------------------------------------------------------------------
// ifu_imem
// Read-only instruction memory with a registered (synchronous) read port.
// The storage array is named im so it can be preloaded through the
// instance hierarchy.
// Ports:
//   clk      in   clock
//   reset    in   async active-high reset (clears the read register only)
//   i_en     in   read enable; o_rdata loads im[i_addr] on the next edge
//   i_addr   in   word index
//   o_rdata  out  registered read data, holds between reads
// -----------------------------------------------------------------------------
module ifu_imem #(
  parameter int IM_WORDS = 1024,
  parameter int AW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_rdata
);

  logic [31:0] im [IM_WORDS];
  logic [31:0] r_rdata;

  // NOTE: only the read register is reset; the storage array is left out of
  // the reset so contents survive it and the array maps onto block RAM.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= im[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mc_ifu.sv
// -----------------------------------------------------------------------------
// mc_ifu
// Multi-cycle instruction fetch unit: PC register, next-PC selection with
// address checking, and a 3-state IDLE/READ/DONE fetch FSM around a
// synchronous instruction memory.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   async active-high reset
//   fetch_req    in   start a fetch at the current pc (honoured in IDLE only)
//   pc_wr        in   load next pc chosen by npc_sel (ignored in READ)
//   npc_sel[1:0] in   00 pc+4, 01 branch, 10 jump, 11 register
//   br_taken     in   branch condition for npc_sel=01
//   rs_val[31:0] in   register target for npc_sel=11
//   pc[31:0]     out  current pc
//   pc_plus4     out  pc+4 (combinational)
//   ir[31:0]     out  instruction register
//   instr_valid  out  one-cycle pulse in DONE
//   busy         out  high in READ and DONE
//   addr_err     out  sticky illegal-next-pc flag
// -----------------------------------------------------------------------------
module mc_ifu
  import mc_ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_wr,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        instr_valid,
  output logic        busy,
  output logic        addr_err
);

  localparam int AW = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;

  state_e        r_state;
  logic [31:0]   r_pc;
  logic [AW-1:0] r_fetch_idx;
  logic          r_valid;
  logic          r_busy;
  logic          r_err;

  logic [31:0]   w_ir;
  logic [AW-1:0] w_pc_idx;
  logic [31:0]   w_npc;
  logic          w_npc_ok;
  logic          w_mem_en;

  // pc is always legal, so the truncated offset is the exact word index.
  assign w_pc_idx = AW'((r_pc - PC_RESET) >> 2);

  assign w_npc    = calc_npc(npc_sel_e'(npc_sel), r_pc, w_ir[25:0], br_taken, rs_val);
  assign w_npc_ok = addr_ok(w_npc, PC_RESET, IM_WORDS);

  assign w_mem_en = (r_state == ST_READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= PC_RESET;
      r_fetch_idx <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          // The index is captured from the pre-edge pc, so a pc_wr on the
          // same edge does not redirect this fetch.
          if (fetch_req && !r_err) begin
            r_state     <= ST_READ;
            r_busy      <= 1'b1;
            r_fetch_idx <= w_pc_idx;
          end
        end
        ST_READ: begin
          r_state <= ST_DONE;
          r_valid <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // pc updates are frozen while the memory read is in flight; an
      // illegal candidate leaves pc alone and latches the error.
      if (pc_wr && (r_state != ST_READ)) begin
        if (w_npc_ok) begin
          r_pc <= w_npc;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // The memory read register doubles as ir: it loads on the READ->DONE
  // edge, holds until the next read, and clears on reset.
  ifu_imem #(
    .IM_WORDS (IM_WORDS),
    .AW       (AW)
  ) u_imem (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_mem_en),
    .i_addr  (r_fetch_idx),
    .o_rdata (w_ir)
  );

  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign ir          = w_ir;
  assign instr_valid = r_valid;
  assign busy        = r_busy;
  assign addr_err    = r_err;

endmodule

// File: doc/mc_ifu.md
MC_IFU -- requirements
Module: mc_ifu

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000: reset and base address of the program.
REQ-002 Parameter IM_WORDS, default 1024: instruction memory depth in 32-bit words.
REQ-003 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port fetch_req  input  1: the controller requests an instruction fetch at the current PC.
REQ-006 Port pc_wr  input  1: load the next PC selected by npc_sel.
REQ-007 Port npc_sel  input  2: next-PC source. 00 = PC+4; 01 = branch; 10 = jump; 11 = register.
REQ-008 Port br_taken  input  1: branch condition; used only when npc_sel=01.
REQ-009 Port rs_val  input  32: register target for npc_sel=11.
REQ-010 Port pc  output  32: current PC.
REQ-011 Port pc_plus4  output  32: PC+4, used as the jal link value.
REQ-012 Port ir  output  32: instruction register.
REQ-013 Port instr_valid  output  1: one-cycle pulse when ir has been loaded.
REQ-014 Port busy  output  1: a fetch is in flight.
REQ-015 Port addr_err  output  1: sticky fault flag.

Function
REQ-016 The block SHALL contain a 3-state FSM: IDLE, READ, DONE.
REQ-017 IDLE SHALL move to READ when fetch_req=1 and addr_err=0; otherwise it stays in IDLE.
REQ-018 READ SHALL always move to DONE.
- READ performs a synchronous memory read at word index (pc-PC_RESET)>>2.
REQ-019 On the READ-to-DONE edge, ir SHALL load the memory word.
- instr_valid SHALL be 1 for exactly the DONE cycle.
- Fetch latency is 2 cycles from fetch_req to instr_valid.
REQ-020 DONE SHALL always return to IDLE.
- Back-to-back fetch_req therefore gives one instruction every 3 cycles.
REQ-021 busy SHALL be 1 in READ and DONE.
REQ-022 fetch_req asserted while busy=1 SHALL be ignored, not queued.
REQ-023 ir SHALL hold its value until the next completed fetch.
REQ-024 pc_wr SHALL take effect only in IDLE or DONE; pc_wr in READ SHALL be ignored.
REQ-025 pc_wr and fetch_req in the same IDLE cycle: the fetch SHALL use the old PC, and pc SHALL update on the same edge.
REQ-026 Next-PC computation:
- 00: pc+4.
- 01: pc+4 + (sign-extended ir[15:0] << 2) when br_taken=1; otherwise pc+4.
- 10: {pc[31:28], ir[25:0], 2'b00}.
- 11: rs_val.
- All arithmetic SHALL be 32-bit modulo 2^32.
REQ-027 A candidate next PC SHALL be rejected when either of these holds:
- its low two bits are nonzero;
- its word index is outside [0, IM_WORDS-1].
- On rejection: pc SHALL be unchanged and addr_err SHALL set.
REQ-028 While addr_err=1, no further fetches SHALL start; pc_wr SHALL still be evaluated.
REQ-029 pc_plus4 SHALL be combinational pc+4.

Reset
REQ-030 Assertion of reset SHALL asynchronously force all of the following, including mid-fetch:
- pc = PC_RESET
- ir = 0
- FSM = IDLE
- instr_valid = 0, busy = 0, addr_err = 0
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 The first fetch SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-033 A shared package SHALL hold:
- the NPC_SEL encodings (PC4, BR, J, JR);
- the FSM state encodings;
- the PC_RESET and IM_WORDS defaults.
REQ-034 Memory SHALL be a separate sub-module, ifu_imem.
- Synchronous read, no write port.
- Storage array named im, so benches can load it with $readmemh through the instance path.

Verification
REQ-035 Reset, then fetch_req with im[0]=32'h3C01_1234 -> instr_valid two cycles later, ir=32'h3C01_1234, pc=32'h0000_3000.
REQ-036 pc_wr with npc_sel=01, br_taken=1, ir[15:0]=16'hFFFF at pc=32'h3008 -> pc=32'h3008.
REQ-037 pc_wr with npc_sel=10, ir[25:0]=26'h0000C03 -> pc=32'h0000_300C; then fetch returns im[3].
REQ-038 pc_wr with npc_sel=11, rs_val=32'h3002 -> pc unchanged, addr_err=1; a following fetch_req is ignored with busy=0.
REQ-039 fetch_req pulsed during READ -> only one instr_valid.
- pc_wr during READ -> pc unchanged.
REQ-040 reset asserted during READ -> immediately pc=32'h3000, busy=0, instr_valid stays 0, ir=0.
